host_cmd_master: RTL and testbench

Host-side command initiator for the multi-clock-domain system's UART command protocol. It accepts one high-level command per handshake (register write, register read, ALU with operands, ALU without operands), expands it into the required sequence of command/argument bytes, and serialises each byte as a UART frame on the system's RX_IN line. It runs in the UART clock domain and is the counterpart of the system's UART receiver and command controller. Uses: bench stimulus generator, and the front end of a host bridge.

---
 rtl/host_cmd_master_pkg.sv | 56 +++++
 rtl/host_cmd_master_frame_tx.sv | 105 ++++++++++
 rtl/host_cmd_master.sv | 200 ++++++++++++++++++++
 tb/tb_host_cmd_master.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/host_cmd_master_pkg.sv
// host_cmd_master_pkg: shared encodings for the host command initiator.
// Command type codes, protocol opcodes, FSM state enums and small helpers
// that map a command type to its opcode byte and to its frame count.
package host_cmd_master_pkg;

    typedef enum logic [1:0] {
        CMD_WR      = 2'd0,
        CMD_RD      = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_type_e;

    localparam logic [7:0] OP_WR      = 8'hAA;
    localparam logic [7:0] OP_RD      = 8'hBB;
    localparam logic [7:0] OP_ALU_OP  = 8'hCC;
    localparam logic [7:0] OP_ALU_NOP = 8'hDD;

    typedef enum logic [2:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_PARITY,
        SER_STOP
    } ser_state_e;

    typedef enum logic [1:0] {
        M_IDLE,
        M_SEND,
        M_GAP
    } mst_state_e;

    // Leading command byte of each command type.
    function automatic logic [7:0] cmd_opcode(input cmd_type_e t);
        logic [7:0] op;
        case (t)
            CMD_WR:     op = OP_WR;
            CMD_RD:     op = OP_RD;
            CMD_ALU_OP: op = OP_ALU_OP;
            default:    op = OP_ALU_NOP;
        endcase
        return op;
    endfunction

    // Number of frames (opcode included) a command expands into.
    function automatic logic [2:0] cmd_len(input cmd_type_e t);
        logic [2:0] n;
        case (t)
            CMD_WR:     n = 3'd3;
            CMD_RD:     n = 3'd2;
            CMD_ALU_OP: n = 3'd4;
            default:    n = 3'd2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/host_cmd_master_frame_tx.sv
// uart_frame_tx: one UART frame per start pulse, MSB first:
// start(0), DATA_WIDTH data bits, optional parity, stop(1).
// A start presented during the last stop cycle chains the next frame
// with no idle cycle in between. Payload, prescale and parity settings
// are captured when the frame starts.
module uart_frame_tx
    import host_cmd_master_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [DATA_WIDTH-1:0]     i_data,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    input  logic                      i_par_en,
    input  logic                      i_par_typ,
    output logic                      o_tx,
    output logic                      o_done
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    ser_state_e                r_state;
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [PRESCALE_WIDTH-1:0] r_max;
    logic [BW-1:0]             r_bit;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic                      r_par_en;
    logic                      r_par_bit;
    logic                      r_tx;

    logic w_tick;
    logic w_load;

    assign w_tick = (r_cnt == r_max);
    assign w_load = i_start &&
                    ((r_state == SER_IDLE) || ((r_state == SER_STOP) && w_tick));

    assign o_tx   = r_tx;
    assign o_done = (r_state == SER_STOP) && w_tick;

    // Frame FSM: bit-period counter, bit sequencing and registered line value.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= SER_IDLE;
            r_cnt     <= '0;
            r_max     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
        end else if (w_load) begin
            r_state   <= SER_START;
            r_tx      <= 1'b0;
            r_cnt     <= '0;
            // a prescale of 0 behaves as 1 cycle per bit
            r_max     <= (i_prescale == '0) ? '0 : i_prescale - 1'b1;
            r_shift   <= i_data;
            r_bit     <= '0;
            r_par_en  <= i_par_en;
            r_par_bit <= (^i_data) ^ i_par_typ;
        end else if (r_state != SER_IDLE) begin
            if (!w_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
                case (r_state)
                    SER_START: begin
                        r_state <= SER_DATA;
                        r_bit   <= '0;
                        r_tx    <= r_shift[DATA_WIDTH-1];
                    end
                    SER_DATA: begin
                        if (r_bit == LAST_BIT) begin
                            if (r_par_en) begin
                                r_state <= SER_PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= SER_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                            r_tx    <= r_shift[DATA_WIDTH-2];
                        end
                    end
                    SER_PARITY: begin
                        r_state <= SER_STOP;
                        r_tx    <= 1'b1;
                    end
                    default: begin
                        r_state <= SER_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/host_cmd_master.sv
// host_cmd_master: accepts one command per handshake, expands it into its
// opcode/argument byte sequence and drives each byte through uart_frame_tx.
// Optional feature macro: INTER_FRAME_GAP_EN inserts GAP_BITS idle bit
// periods after every frame of a command (including the last one).
module host_cmd_master
    import host_cmd_master_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int PRESCALE_WIDTH = 6,
    parameter int GAP_BITS       = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic [1:0]                i_cmd_type,
    input  logic [ADDR_WIDTH-1:0]     i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]     i_cmd_data_a,
    input  logic [DATA_WIDTH-1:0]     i_cmd_data_b,
    input  logic [3:0]                i_cmd_func,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    input  logic                      i_par_en,
    input  logic                      i_par_typ,
    output logic                      o_tx_out,
    output logic                      o_busy,
    output logic                      o_frame_done
);

    mst_state_e                r_state;
    cmd_type_e                 r_type;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_data_a;
    logic [DATA_WIDTH-1:0]     r_data_b;
    logic [3:0]                r_func;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_par_en;
    logic                      r_par_typ;
    logic [2:0]                r_idx;      // index of the next byte to send
    logic                      r_ready;
    logic                      r_busy;

    logic                      w_accept;
    logic                      w_done;
    logic                      w_last;
    logic                      w_next;
    logic                      w_ser_start;
    logic [DATA_WIDTH-1:0]     w_byte;
    logic [DATA_WIDTH-1:0]     w_ser_data;
    logic [PRESCALE_WIDTH-1:0] w_ser_ps;
    logic                      w_ser_par_en;
    logic                      w_ser_par_typ;

    assign w_accept = i_cmd_valid && r_ready;
    assign w_last   = (r_idx == cmd_len(r_type));

`ifdef INTER_FRAME_GAP_EN
    localparam int GW = PRESCALE_WIDTH + $clog2(GAP_BITS + 1) + 1;

    logic [GW-1:0]             r_gap_cnt;
    logic [PRESCALE_WIDTH-1:0] w_ps_eff;
    logic [GW-1:0]             w_gap_len;
    logic                      w_gap_end;

    assign w_ps_eff  = (r_prescale == '0) ? PRESCALE_WIDTH'(1) : r_prescale;
    assign w_gap_len = GW'(GAP_BITS) * GW'(w_ps_eff);
    assign w_gap_end = ((r_gap_cnt + 1'b1) >= w_gap_len);
    assign w_next    = (r_state == M_GAP) && w_gap_end && !w_last;
`else
    assign w_next    = (r_state == M_SEND) && w_done && !w_last;
`endif

    assign w_ser_start = w_accept || w_next;

    // Argument byte for the current index of the held command.
    always_comb begin
        w_byte = '0;
        case (r_type)
            CMD_WR: begin
                if (r_idx == 3'd1) w_byte = DATA_WIDTH'(r_addr);
                else               w_byte = r_data_a;
            end
            CMD_RD: begin
                w_byte = DATA_WIDTH'(r_addr);
            end
            CMD_ALU_OP: begin
                if (r_idx == 3'd1)      w_byte = r_data_a;
                else if (r_idx == 3'd2) w_byte = r_data_b;
                else                    w_byte = DATA_WIDTH'(r_func);
            end
            default: begin
                w_byte = DATA_WIDTH'(r_func);
            end
        endcase
    end

    // The opcode frame starts on the acceptance edge itself, so it is fed
    // straight from the inputs; later frames come from the held command.
    assign w_ser_data    = w_accept ? DATA_WIDTH'(cmd_opcode(cmd_type_e'(i_cmd_type))) : w_byte;
    assign w_ser_ps      = w_accept ? i_prescale : r_prescale;
    assign w_ser_par_en  = w_accept ? i_par_en   : r_par_en;
    assign w_ser_par_typ = w_accept ? i_par_typ  : r_par_typ;

    uart_frame_tx #(
        .DATA_WIDTH     (DATA_WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_frame_tx (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (w_ser_start),
        .i_data     (w_ser_data),
        .i_prescale (w_ser_ps),
        .i_par_en   (w_ser_par_en),
        .i_par_typ  (w_ser_par_typ),
        .o_tx       (o_tx_out),
        .o_done     (w_done)
    );

    assign o_cmd_ready  = r_ready;
    assign o_busy       = r_busy;
    assign o_frame_done = w_done;

    // Master FSM: command capture, byte sequencing and optional gap timing.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= M_IDLE;
            r_type     <= CMD_WR;
            r_addr     <= '0;
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_func     <= '0;
            r_prescale <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_idx      <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
`ifdef INTER_FRAME_GAP_EN
            r_gap_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                M_IDLE: begin
                    if (i_cmd_valid) begin
                        r_type     <= cmd_type_e'(i_cmd_type);
                        r_addr     <= i_cmd_addr;
                        r_data_a   <= i_cmd_data_a;
                        r_data_b   <= i_cmd_data_b;
                        r_func     <= i_cmd_func;
                        r_prescale <= i_prescale;
                        r_par_en   <= i_par_en;
                        r_par_typ  <= i_par_typ;
                        r_idx      <= 3'd1;
                        r_state    <= M_SEND;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                M_SEND: begin
                    if (w_done) begin
`ifdef INTER_FRAME_GAP_EN
                        r_state   <= M_GAP;
                        r_gap_cnt <= '0;
`else
                        if (w_last) begin
                            r_state <= M_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
`endif
                    end
                end
`ifdef INTER_FRAME_GAP_EN
                M_GAP: begin
                    if (w_gap_end) begin
                        if (w_last) begin
                            r_state <= M_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= M_SEND;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= M_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_cmd_master.sv
// tb_host_cmd_master: directed commands with hand-computed frame images.
// Stimulus pushes expected frames into a scoreboard queue; a monitor
// decodes TX_OUT (mid-bit sampling) and FRAME_DONE position per frame.
module tb_host_cmd_master;

    localparam int PSW = 6;
`ifdef INTER_FRAME_GAP_EN
    localparam int GAP_MUL = 2;
`else
    localparam int GAP_MUL = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_type = '0;
    logic [3:0]     cmd_addr = '0;
    logic [7:0]     cmd_data_a = '0;
    logic [7:0]     cmd_data_b = '0;
    logic [3:0]     cmd_func = '0;
    logic [PSW-1:0] prescale = '0;
    logic           par_en = 1'b0;
    logic           par_typ = 1'b0;
    logic           tx_out;
    logic           busy;
    logic           frame_done;

    always #5 clk = ~clk;

    host_cmd_master #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .PRESCALE_WIDTH(PSW), .GAP_BITS(2)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_type(cmd_type), .i_cmd_addr(cmd_addr), .i_cmd_data_a(cmd_data_a),
        .i_cmd_data_b(cmd_data_b), .i_cmd_func(cmd_func), .i_prescale(prescale),
        .i_par_en(par_en), .i_par_typ(par_typ), .o_tx_out(tx_out), .o_busy(busy),
        .o_frame_done(frame_done)
    );

    typedef struct {
        logic [11:0] bits;   // first bit on the line is bits[nbits-1]
        int          nbits;
        int          ps;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [11:0] b, input int n, input int ps);
        exp_t e;
        e.bits = b; e.nbits = n; e.ps = ps; e.gap = GAP_MUL * ps;
        sb.push_back(e);
    endtask

    // Monitor: triggers on a start bit whenever a frame is expected.
    initial begin
        exp_t        e;
        logic [11:0] got;
        int          total;
        int          done_bad;
        int          gap_bad;
        forever begin
            @(negedge clk);
            if (rst_n && tx_out == 1'b0 && sb.size() > 0) begin
                e = sb.pop_front();
                got = '0;
                done_bad = 0;
                total = e.nbits * e.ps;
                for (int c = 0; c < total; c++) begin
                    if (c > 0) @(negedge clk);
                    if ((c % e.ps) == (e.ps / 2)) got = {got[10:0], tx_out};
                    if (frame_done !== (c == total - 1)) done_bad++;
                end
                chk("frame_bits", got, e.bits);
                chk("frame_done_pos", done_bad, 0);
                if (e.gap > 0) begin
                    gap_bad = 0;
                    for (int g = 0; g < e.gap; g++) begin
                        @(negedge clk);
                        if (tx_out !== 1'b1 || frame_done !== 1'b0) gap_bad++;
                    end
                    chk("gap_idle", gap_bad, 0);
                end
            end
        end
    end

    // Accepts one command; returns at the negedge of the first busy cycle.
    task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] da,
                         input logic [7:0] db, input logic [3:0] f, input logic [PSW-1:0] ps,
                         input logic pe, input logic pt, input bit scramble);
        @(negedge clk);
        cmd_type = t; cmd_addr = a; cmd_data_a = da; cmd_data_b = db; cmd_func = f;
        prescale = ps; par_en = pe; par_typ = pt; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (scramble) begin
            // keep VALID high too: must be ignored while busy
            prescale = 6'd7; par_typ = ~pt; cmd_type = 2'd3; cmd_data_a = 8'h00;
        end else begin
            cmd_valid = 1'b0;
        end
        @(negedge clk);
        chk("busy_after_accept", busy, 1'b1);
        chk("ready_after_accept", cmd_ready, 1'b0);
        chk("start_bit_k1", tx_out, 1'b0);
    endtask

    task automatic wait_idle(input string name, input int exp_busy);
        int cnt;
        cnt = 1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        cmd_valid = 1'b0;
        chk(name, cnt, exp_busy);
        chk("ready_at_end", cmd_ready, 1'b1);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_out, 1'b1);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: WR addr 4 data 0xAA, ps 8, even parity
        push(12'b0_10101010_0_1, 11, 8);
        push(12'b0_00000100_1_1, 11, 8);
        push(12'b0_10101010_0_1, 11, 8);
        issue(2'd0, 4'd4, 8'hAA, 8'h00, 4'd0, 6'd8, 1'b1, 1'b0, 1'b0);
        wait_idle("t1_busy_cycles", 264 + 3 * GAP_MUL * 8);

        // Test 2: RD addr 4, odd parity, ps 32
        push(12'b0_10111011_1_1, 11, 32);
        push(12'b0_00000100_0_1, 11, 32);
        issue(2'd1, 4'd4, 8'h00, 8'h00, 4'd0, 6'd32, 1'b1, 1'b1, 1'b0);
        wait_idle("t2_busy_cycles", 704 + 2 * GAP_MUL * 32);

        // Test 3: ALU_OP A=10 B=6 FUNC=2, no parity, ps 4
        push(12'b0_11001100_1, 10, 4);
        push(12'b0_00001010_1, 10, 4);
        push(12'b0_00000110_1, 10, 4);
        push(12'b0_00000010_1, 10, 4);
        issue(2'd2, 4'd0, 8'd10, 8'd6, 4'd2, 6'd4, 1'b0, 1'b0, 1'b0);
        wait_idle("t3_busy_cycles", 160 + 4 * GAP_MUL * 4);

        // Test 4: ALU_NOP FUNC=1, ps 8 (gaps of 16 cycles when enabled)
        push(12'b0_11011101_1, 10, 8);
        push(12'b0_00000001_1, 10, 8);
        issue(2'd3, 4'd0, 8'h00, 8'h00, 4'd1, 6'd8, 1'b0, 1'b0, 1'b0);
        wait_idle("t4_busy_cycles", 160 + 2 * GAP_MUL * 8);

        // Test 5: WR addr 3 data 0x5A, odd parity, ps 4; inputs disturbed mid-command
        push(12'b0_10101010_1_1, 11, 4);
        push(12'b0_00000011_1_1, 11, 4);
        push(12'b0_01011010_1_1, 11, 4);
        issue(2'd0, 4'd3, 8'h5A, 8'h00, 4'd0, 6'd4, 1'b1, 1'b1, 1'b1);
        wait_idle("t5_busy_cycles", 132 + 3 * GAP_MUL * 4);

        // Test 7: prescale 0 behaves as 1; RD addr 0xF, no parity
        push(12'b0_10111011_1, 10, 1);
        push(12'b0_00001111_1, 10, 1);
        issue(2'd1, 4'hF, 8'h00, 8'h00, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0);
        wait_idle("t7_busy_cycles", 20 + 2 * GAP_MUL);

        // Test 6: reset inside the data bits of the second frame (nothing expected)
        issue(2'd0, 4'd2, 8'h11, 8'h00, 4'd0, 6'd4, 1'b1, 1'b0, 1'b0);
        repeat (62 + GAP_MUL * 4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_tx", tx_out, 1'b1);
        chk("t6_rst_ready", cmd_ready, 1'b1);
        chk("t6_rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle_tx", tx_out, 1'b1);
        push(12'b0_10101010_1, 10, 3);
        push(12'b0_00000001_1, 10, 3);
        push(12'b0_10000001_1, 10, 3);
        issue(2'd0, 4'd1, 8'h81, 8'h00, 4'd0, 6'd3, 1'b0, 1'b0, 1'b0);
        wait_idle("t6_busy_cycles", 90 + 3 * GAP_MUL * 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
